// File: rtl/mux_disp_scan.sv
// rtl/mux_disp_scan.sv - multiplexed 7-segment display scanner with tear-free double buffer
//
// Scans NUM_DIGITS digits, one per SCAN_DIV clock cycles, driving
// active-low segments and active-low one-hot digit enables.
// New data is captured into a pending register and only promoted
// to the display register at a frame wrap, so a frame never mixes
// old and new digits.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   defined   -> zero digits above the most-significant nonzero
//                digit are dark (digit 0 is always lit)
//   undefined -> every digit is shown, leading zeros included
//
// Ports:
//   clk_i        - clock, rising edge
//   rst_n_i      - synchronous active-low reset
//   data_i       - packed digit values, digit k at [k*DIGIT_W +: DIGIT_W]
//   load_i       - one-cycle strobe capturing data_i
//   blank_i      - level, 1 turns the whole display off
//   seg_o        - active-low segments {g,f,e,d,c,b,a}, registered
//   an_o         - active-low digit enables, registered
//   digit_idx_o  - index of the digit currently driven, registered
//   frame_o      - one-cycle pulse in the cycle after a scan wrap
module mux_disp_scan #(
    parameter int NUM_DIGITS = 8,
    parameter int DIGIT_W    = 3,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]   data_i,
    input  logic                            load_i,
    input  logic                            blank_i,
    output logic [6:0]                      seg_o,
    output logic [NUM_DIGITS-1:0]           an_o,
    output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx_o,
    output logic                            frame_o
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int DATA_W = NUM_DIGITS * DIGIT_W;

    logic [PRE_W-1:0]   presc_q;
    logic [IDX_W-1:0]   scan_idx_q;
    logic [DATA_W-1:0]  pending_q;
    logic               pending_valid_q;
    logic [DATA_W-1:0]  display_q;

    logic               tc;
    logic               wrap_tc;
    logic [DIGIT_W-1:0] cur_digit;
    logic               lz_blank;
    logic [NUM_DIGITS-1:0] an_next;
    logic [6:0]         seg_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign tc      = (presc_q == PRE_W'(SCAN_DIV - 1));
    assign wrap_tc = tc && (scan_idx_q == IDX_W'(NUM_DIGITS - 1));

    always_comb begin
        cur_digit = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (scan_idx_q == IDX_W'(k)) begin
                cur_digit = display_q[k*DIGIT_W +: DIGIT_W];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Walk from the top digit down; a digit is dark while it and every
    // digit above it are zero. Digit 0 is excluded so zero shows as "0".
    logic upper_zero;
    always_comb begin
        upper_zero = 1'b1;
        lz_blank   = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (display_q[k*DIGIT_W +: DIGIT_W] == '0);
            if (scan_idx_q == IDX_W'(k)) begin
                lz_blank = upper_zero;
            end
        end
    end
`else
    assign lz_blank = 1'b0;
`endif

    assign an_next  = ~(NUM_DIGITS'(1) << scan_idx_q);
    assign seg_next = seg_decode(4'(cur_digit));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            presc_q         <= '0;
            scan_idx_q      <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            display_q       <= '0;
            seg_o           <= 7'h7F;
            an_o            <= '1;
            digit_idx_o     <= '0;
            frame_o         <= 1'b0;
        end else begin
            presc_q <= tc ? '0 : presc_q + 1'b1;
            if (tc) begin
                scan_idx_q <= wrap_tc ? '0 : scan_idx_q + 1'b1;
            end
            frame_o <= wrap_tc;

            // A load landing on the wrap goes straight to display; otherwise
            // it waits in pending until the next wrap.
            if (load_i && wrap_tc) begin
                display_q       <= data_i;
                pending_valid_q <= 1'b0;
            end else if (load_i) begin
                pending_q       <= data_i;
                pending_valid_q <= 1'b1;
            end else if (wrap_tc && pending_valid_q) begin
                display_q       <= pending_q;
                pending_valid_q <= 1'b0;
            end

            digit_idx_o <= scan_idx_q;
            if (blank_i || lz_blank) begin
                an_o  <= '1;
                seg_o <= 7'h7F;
            end else begin
                an_o  <= an_next;
                seg_o <= seg_next;
            end
        end
    end

endmodule

// File: tb/tb_mux_disp_scan.sv
// tb/tb_mux_disp_scan.sv - scoreboard testbench for mux_disp_scan (8 octal digits, SCAN_DIV=4)
module tb_mux_disp_scan;

    logic        clk;
    logic        rst_n;
    logic [23:0] data;
    logic        load;
    logic        blank;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic [2:0]  didx;
    logic        frame;

    int n_cmp  = 0;
    int n_fail = 0;
    int k      = 0;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic [2:0] idx;
        logic       frame;
    } exp_t;

    exp_t sb[$];

    logic [6:0] seg_tab [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    mux_disp_scan #(
        .NUM_DIGITS (8),
        .DIGIT_W    (3),
        .SCAN_DIV   (4)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .data_i      (data),
        .load_i      (load),
        .blank_i     (blank),
        .seg_o       (seg),
        .an_o        (an),
        .digit_idx_o (didx),
        .frame_o     (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs after the kk-th rising edge since reset release,
    // given the word that should be on the display during that slot.
    function automatic exp_t model(int kk, logic [23:0] w, logic blk);
        exp_t e;
        int   idx;
        logic [2:0] d;
        logic dark;
        idx  = ((kk - 1) / 4) % 8;
        d    = w[idx*3 +: 3];
        dark = blk;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            int msnz;
            msnz = 0;
            for (int i = 0; i < 8; i++) begin
                if (w[i*3 +: 3] != 3'd0) msnz = i;
            end
            if (idx > msnz) dark = 1'b1;
        end
`endif
        e.idx   = 3'(idx);
        e.frame = (kk % 32 == 0);
        e.an    = dark ? 8'hFF : ~(8'h01 << idx);
        e.seg   = dark ? 7'h7F : seg_tab[4'(d)];
        return e;
    endfunction

    task automatic check_pop();
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        assert (an === e.an) else begin
            n_fail++;
            $error("FAIL an k=%0d observed=%h expected=%h", k, an, e.an);
        end
        n_cmp++;
        assert (seg === e.seg) else begin
            n_fail++;
            $error("FAIL seg k=%0d observed=%b expected=%b", k, seg, e.seg);
        end
        n_cmp++;
        assert (didx === e.idx) else begin
            n_fail++;
            $error("FAIL digit_idx k=%0d observed=%0d expected=%0d", k, didx, e.idx);
        end
        n_cmp++;
        assert (frame === e.frame) else begin
            n_fail++;
            $error("FAIL frame k=%0d observed=%b expected=%b", k, frame, e.frame);
        end
    endtask

    task automatic step(logic [23:0] shown);
        sb.push_back(model(k + 1, shown, blank));
        @(posedge clk);
        k++;
        @(negedge clk);
        check_pop();
    endtask

    task automatic reset_step();
        exp_t e;
        e.an = 8'hFF; e.seg = 7'h7F; e.idx = 3'd0; e.frame = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        check_pop();
    endtask

    task automatic run_to(int k_end, logic [23:0] shown);
        while (k < k_end) step(shown);
    endtask

    task automatic do_load(logic [23:0] w_new, logic [23:0] shown);
        data = w_new;
        load = 1'b1;
        step(shown);
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        data  = '0;
        load  = 1'b0;
        blank = 1'b0;

        // Reset held for 3 cycles, then first slot shows digit 0 = "0"
        repeat (3) reset_step();
        rst_n = 1'b1;
        k = 0;
        run_to(31, 24'o0);

        // Coincident load at the wrap edge: new data from the next digit 0
        do_load(24'o76543210, 24'o0);
        run_to(64, 24'o76543210);

        // Mid-frame load: rest of frame keeps old data
        run_to(75, 24'o76543210);
        do_load(24'o11111111, 24'o76543210);
        run_to(96, 24'o76543210);
        run_to(128, 24'o11111111);

        // Two loads in one frame: only the second reaches the display
        run_to(131, 24'o11111111);
        do_load(24'o22222222, 24'o11111111);
        run_to(139, 24'o11111111);
        do_load(24'o33333333, 24'o11111111);
        run_to(160, 24'o11111111);
        run_to(192, 24'o33333333);

        // Pending load then a coincident load: coincident wins, pending dropped
        run_to(199, 24'o33333333);
        do_load(24'o44444444, 24'o33333333);
        run_to(223, 24'o33333333);
        do_load(24'o55555555, 24'o33333333);
        run_to(288, 24'o55555555);

        // Blank for 10 cycles; scanning continues underneath
        run_to(289, 24'o55555555);
        blank = 1'b1;
        run_to(299, 24'o55555555);
        blank = 1'b0;
        run_to(320, 24'o55555555);

        // Leading zeros (dark only when LEADING_ZERO_BLANK_EN is defined)
        run_to(351, 24'o55555555);
        do_load(24'o00000305, 24'o55555555);
        run_to(383, 24'o00000305);
        do_load(24'o0, 24'o00000305);
        run_to(416, 24'o0);

        // Reset mid-frame discards a pending load
        run_to(425, 24'o0);
        do_load(24'o77777777, 24'o0);
        run_to(430, 24'o0);
        rst_n = 1'b0;
        repeat (2) reset_step();
        rst_n = 1'b1;
        k = 0;
        run_to(70, 24'o0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
